// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit: one full-adder slice plus a carry flop processes
// WIDTH-bit operands LSB first, trading WIDTH+1 cycles of latency for area.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  // Handshake: start is accepted only at an IDLE edge, capturing a, b and sub;
  // busy covers the WIDTH RUN cycles, and done pulses for one cycle once
  // sum/cout/ovf have been updated. start is ignored while busy or done.

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-2:0] res;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    count;
  logic             bit_s, bit_c;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (count == LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign state_dbg = state;

  assign bit_s    = op_a[0] ^ op_b[0] ^ carry;
  assign bit_c    = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
  // Result bits collected so far, with the current bit entering at the top.
  assign res_next = {bit_s, res};

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            count <= '0;
          end
        end
        RUN: begin
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          res   <= res_next[WIDTH-1:1];
          carry <= bit_c;
          count <= count + 1'b1;
          if (count == LAST) begin
            // carry still holds the carry into the MSB here; bit_c is the carry out.
            sum  <= res_next;
            cout <= bit_c;
            ovf  <= carry ^ bit_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
